output_block: RTL and testbench
===============================

Name: output_block

Overview:
- Transmit-side counterpart of the crossbar input block: serialises parallel bytes onto one serdes lane, one instance per crossbar port.
- Bytes from the switch fabric are buffered in a small FIFO.
- Each byte goes out as a 10-bit frame: start bit 0, DATA_W data bits LSB-first, stop bit 1.
- Frames start only on the shared clk10 frame strobe, so every lane stays frame-aligned with the input side.

Parameters:
- DATA_W, 8, payload bits per frame. Frame length is DATA_W+2 and must equal the clk10 period; only 8 is supported.
- FIFO_DEPTH, 4, entries in the input FIFO; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- clk10  input  1  frame strobe, high for 1 cycle every 10 clk cycles
- in_data  input  DATA_W  byte from the fabric
- in_valid  input  1  in_data is valid
- in_ready  output  1  FIFO can accept; combinational, (fifo_count < FIFO_DEPTH)
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- tx_serial  output  1  serial lane, registered, idles high
- tx_active  output  1  frame in progress
- tx_done  output  1  1-cycle pulse in the cycle the stop bit is driven
- frame_err  output  1  sticky error: clk10 arrived mid-frame
- err_clr  input  1  synchronous clear of frame_err

Behaviour:
- Reset (async, rst=1): tx_serial=1, tx_active=0, tx_done=0, frame_err=0, FIFO empty (fifo_count=0, in_ready=1), state=IDLE, bit_cnt=0, shift register all ones.
- FIFO push: on a clk edge with in_valid && in_ready. When full, in_ready=0 and in_valid is ignored; no overwrite.
- FIFO pop: only on a frame load (below). A push and a pop on the same edge leave fifo_count unchanged; push to a full FIFO with a simultaneous pop is not allowed (in_ready is low).
- State machine:
  - IDLE:
    - tx_serial=1.
    - On an edge where clk10=1 and FIFO is non-empty: load shift reg {1, head, 0}, pop, tx_serial<=0, bit_cnt<=0, go to SEND, tx_active<=1.
    - clk10 with an empty FIFO: stay IDLE.
  - SEND:
    - Each edge: shift right, tx_serial<=next bit, bit_cnt++.
    - tx_serial order over the 10 cycles after the load edge: start 0, d0..d7, stop 1.
    - tx_done=1 during the stop-bit cycle (bit_cnt==9).
  - End of frame, edge with bit_cnt==9:
    - clk10=1 and FIFO non-empty: back-to-back load of the next frame; no idle gap, tx_active stays 1.
    - Otherwise: go to IDLE, tx_serial<=1, tx_active<=0.
- Misalignment:
  - clk10=1 in SEND with bit_cnt!=9: set frame_err; the strobe is ignored and the current frame completes normally.
  - bit_cnt==9 without clk10: frame ends; the next load waits for the next clk10.
- err_clr=1 clears frame_err at the edge. If a new error occurs on the same edge, the set wins.
- Latency: byte pushed at edge P with an empty FIFO and IDLE goes out with the first clk10 edge strictly after P. The start bit is visible on tx_serial during the cycle after that edge.
- Reset mid-frame: tx_serial returns to 1 immediately (async), the frame is abandoned, FIFO contents are discarded.
- Throughput: one byte per 10 cycles maximum.

Test Plan:
- Reset, no traffic, clk10 running 200 cycles -> tx_serial=1, tx_active=0, in_ready=1, fifo_count=0 throughout.
- Push 0xA5 at cycle 3, clk10 at cycles 9,19,29 -> tx_serial over cycles 10..19 = 0,1,0,1,0,0,1,0,1,1; tx_done high at cycle 19; tx_active low from cycle 20 (FIFO empty at edge 19).
- Push 0x00, 0xFF, 0x3C back-to-back before first clk10 -> three contiguous frames with no idle bits:
  - 0,0×8,1
  - 0,1×8,1
  - 0,0,0,1,1,1,1,0,0,1
  - fifo_count steps 3→2→1→0.
- Push 6 bytes with clk10 held low (FIFO_DEPTH=4) -> in_ready=0 after 4th push, 5th and 6th dropped, fifo_count=4; after strobes only the first 4 bytes are transmitted.
- Extra clk10 pulse at bit_cnt=4 of a frame -> frame_err=1 and the frame still completes with the correct bits. err_clr pulse -> frame_err=0. err_clr together with another misaligned strobe -> frame_err stays 1.
- Assert rst at bit_cnt=5 of a 0x5A frame -> tx_serial=1 and fifo_count=0 in the same cycle. After release, no residual bits are sent until a new push and clk10.

Source files
------------

// File: rtl/output_block.sv
// output_block: FIFO-buffered serialiser for one crossbar lane. Each byte leaves as a
// 10-bit frame (start 0, data LSB-first, stop 1), launched only on the shared clk10 strobe.
module output_block #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk10,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_serial,
    output logic                        tx_active,
    output logic                        tx_done,
    output logic                        frame_err,
    input  logic                        err_clr
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FRAME_W = DATA_W + 2;

    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_W - 1);
    localparam logic [3:0]       STOP_PREV = 4'(FRAME_W - 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [DATA_W-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    state_t             state_r;
    state_t             state_s;
    logic [FRAME_W-1:0] shift_r;
    logic [FRAME_W-1:0] shift_s;
    logic [3:0]         bit_cnt_r;
    logic [3:0]         bit_cnt_s;
    logic               tx_serial_r;
    logic               tx_serial_s;
    logic               tx_active_r;
    logic               tx_active_s;
    logic               tx_done_r;
    logic               tx_done_s;
    logic               frame_err_r;
    logic               frame_err_s;
    logic               err_set_s;

    logic               fifo_empty_s;
    logic               push_s;
    logic               load_s;

    assign in_ready     = (count_r < FULL_CNT);
    assign fifo_empty_s = (count_r == ZERO_CNT);
    assign push_s       = in_valid && in_ready;

    // A frame is loaded only on the strobe, either from idle or exactly at the stop bit.
    assign load_s = clk10 && !fifo_empty_s &&
                    ((state_r == ST_IDLE) || ((state_r == ST_SEND) && (bit_cnt_r == LAST_BIT)));

    assign fifo_count = count_r;
    assign tx_serial  = tx_serial_r;
    assign tx_active  = tx_active_r;
    assign tx_done    = tx_done_r;
    assign frame_err  = frame_err_r;

    // FIFO storage write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pops happen only on a frame load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, load_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state and next-output logic of the serialiser
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        bit_cnt_s   = bit_cnt_r;
        tx_serial_s = tx_serial_r;
        tx_active_s = tx_active_r;
        tx_done_s   = 1'b0;
        err_set_s   = 1'b0;

        if (load_s) begin
            shift_s     = {1'b1, mem_r[rd_ptr_r], 1'b0};
            tx_serial_s = 1'b0;
            bit_cnt_s   = 4'd0;
            state_s     = ST_SEND;
            tx_active_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    shift_s     = {FRAME_W{1'b1}};
                    bit_cnt_s   = 4'd0;
                    tx_serial_s = 1'b1;
                    tx_active_s = 1'b0;
                end
                ST_SEND: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s     = ST_IDLE;
                        shift_s     = {FRAME_W{1'b1}};
                        bit_cnt_s   = 4'd0;
                        tx_serial_s = 1'b1;
                        tx_active_s = 1'b0;
                    end else begin
                        // Bit 0 is already on the line, so the next bit to drive is bit 1.
                        shift_s     = {1'b1, shift_r[FRAME_W-1:1]};
                        tx_serial_s = shift_r[1];
                        bit_cnt_s   = bit_cnt_r + 4'd1;
                        tx_done_s   = (bit_cnt_r == STOP_PREV);
                        err_set_s   = clk10;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    shift_s     = {FRAME_W{1'b1}};
                    bit_cnt_s   = 4'd0;
                    tx_serial_s = 1'b1;
                    tx_active_s = 1'b0;
                end
            endcase
        end

        if (err_set_s) begin
            frame_err_s = 1'b1;
        end else if (err_clr) begin
            frame_err_s = 1'b0;
        end else begin
            frame_err_s = frame_err_r;
        end
    end

    // Serialiser state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= {FRAME_W{1'b1}};
            bit_cnt_r   <= 4'd0;
            tx_serial_r <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            bit_cnt_r   <= bit_cnt_s;
            tx_serial_r <= tx_serial_s;
            tx_active_r <= tx_active_s;
            tx_done_r   <= tx_done_s;
            frame_err_r <= frame_err_s;
        end
    end

endmodule

// File: tb/tb_output_block.sv
// tb_output_block: randomized and directed stimulus for output_block, checked every cycle
// against a queue-based frame model plus hand-computed literal expectations.
module tb_output_block;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk10 = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       in_ready;
    logic [2:0] fifo_count;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;
    logic       frame_err;

    int checks = 0;
    int failures = 0;

    output_block #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk10      (clk10),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_count (fifo_count),
        .tx_serial  (tx_serial),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Model: queued bytes, the frame on the line as a bit list, and the position in it.
    logic [7:0] mq[$];
    logic       busy = 1'b0;
    logic [3:0] pos = 4'd0;
    logic       err = 1'b0;
    logic [9:0] frame_m = 10'h3FF;
    logic       m_push;
    logic       m_load;
    logic [7:0] m_byte;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bitof(input logic [29:0] v, input int i);
        return int'((v >> i) & 30'd1);
    endfunction

    // Model update on every rising edge, using the inputs the DUT sees
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            busy = 1'b0;
            pos = 4'd0;
            err = 1'b0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_load = clk10 && (mq.size() > 0) && (!busy || pos == 4'd9);
            if (clk10 && busy && pos != 4'd9) err = 1'b1;
            else if (err_clr) err = 1'b0;
            if (m_load) begin
                m_byte = mq.pop_front();
                frame_m[0] = 1'b0;
                for (int k = 0; k < 8; k++) frame_m[k+1] = m_byte[k];
                frame_m[9] = 1'b1;
                pos = 4'd0;
                busy = 1'b1;
            end else if (busy && pos == 4'd9) begin
                busy = 1'b0;
                pos = 4'd0;
            end else if (busy) begin
                pos = pos + 4'd1;
            end
            if (m_push) mq.push_back(in_data);
        end
    end

    // Compare DUT outputs against the model away from the active edge
    always @(negedge clk) begin
        chk("tx_serial", int'(tx_serial), busy ? int'(frame_m[pos]) : 1);
        chk("tx_active", int'(tx_active), int'(busy));
        chk("tx_done", int'(tx_done), int'(busy && pos == 4'd9));
        chk("frame_err", int'(frame_err), int'(err));
        chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
        chk("fifo_count", int'(fifo_count), mq.size());
    end

    task automatic step(input logic v, input logic [7:0] d, input logic c10, input logic clr);
        in_valid = v;
        in_data = d;
        clk10 = c10;
        err_clr = clr;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clk10 = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] pat;
        logic [29:0] got;
        int done_cnt;
        logic rc10;

        repeat (3) @(negedge clk);
        chk("rst_tx_serial", int'(tx_serial), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_frame_err", int'(frame_err), 0);
        rst = 1'b0;

        // Idle lane with the strobe running
        for (int e = 0; e < 200; e++) step(1'b0, 8'h00, (e % 10) == 9, 1'b0);
        chk("idle_tx_serial", int'(tx_serial), 1);
        chk("idle_tx_active", int'(tx_active), 0);

        // Single byte 0xA5
        pat = 30'b11_0100_1010;
        for (int e = 0; e <= 30; e++) begin
            step(e == 3, 8'hA5, (e % 10) == 9, 1'b0);
            if (e >= 9 && e <= 18) chk("a5_bit", int'(tx_serial), bitof(pat, e - 9));
            if (e == 18) chk("a5_done", int'(tx_done), 1);
            if (e == 19) chk("a5_active_low", int'(tx_active), 0);
        end

        // Three back-to-back frames 0x00, 0xFF, 0x3C
        pat = {10'b10_0111_1000, 10'b11_1111_1110, 10'b10_0000_0000};
        got = 30'd0;
        for (int e = 0; e <= 40; e++) begin
            step(e <= 2, (e == 0) ? 8'h00 : (e == 1) ? 8'hFF : 8'h3C, (e % 10) == 9, 1'b0);
            if (e >= 9 && e <= 38) got[e - 9] = tx_serial;
            if (e == 2) chk("b2b_count3", int'(fifo_count), 3);
            if (e == 9) chk("b2b_count2", int'(fifo_count), 2);
            if (e == 19) chk("b2b_count1", int'(fifo_count), 1);
            if (e == 29) chk("b2b_count0", int'(fifo_count), 0);
            if (e == 28) chk("b2b_active", int'(tx_active), 1);
        end
        chk("b2b_stream", int'(got == pat), 1);

        // Overfill with the strobe held low
        done_cnt = 0;
        for (int e = 0; e < 56; e++) begin
            step(e <= 5, 8'(8'h11 * (e + 1)), (e >= 6) && ((e % 10) == 9), 1'b0);
            if (e == 3) chk("full_in_ready", int'(in_ready), 0);
            if (e == 5) begin
                chk("full_count", int'(fifo_count), 4);
                chk("model_full", mq.size(), 4);
            end
            if (tx_done) done_cnt++;
        end
        chk("full_frames", done_cnt, 4);

        // Misaligned strobes and error clear
        pat = 30'b11_0010_1100;
        got = 30'd0;
        for (int e = 0; e <= 40; e++) begin
            step((e == 0) || (e == 23), (e == 0) ? 8'h96 : 8'h42,
                 ((e % 10) == 9) || (e == 14) || (e == 31) || (e == 33),
                 (e == 22) || (e == 33));
            if (e >= 9 && e <= 18) got[e - 9] = tx_serial;
            if (e == 14) chk("err_set", int'(frame_err), 1);
            if (e == 22) chk("err_clr", int'(frame_err), 0);
            if (e == 33) chk("err_set_wins", int'(frame_err), 1);
        end
        chk("err_frame_bits", int'(got == pat), 1);

        // Reset in the middle of a 0x5A frame with another byte queued
        for (int e = 0; e <= 14; e++) step(e <= 1, (e == 0) ? 8'h5A : 8'h77, (e % 10) == 9, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx_serial", int'(tx_serial), 1);
        chk("midrst_fifo_count", int'(fifo_count), 0);
        chk("midrst_tx_active", int'(tx_active), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 30; e++) begin
            step(1'b0, 8'h00, (e % 10) == 9, 1'b0);
            if (tx_active) done_cnt++;
        end
        chk("postrst_quiet", done_cnt, 0);

        // Randomized traffic with occasional stray strobes and clears
        for (int i = 0; i < 2000; i++) begin
            rc10 = ((i % 10) == 9) || ($urandom_range(0, 59) == 0);
            step($urandom_range(0, 3) == 0, 8'($urandom), rc10, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
